// File: rtl/apb_slave_regfile.sv
// APB completer holding NUM_REGS word registers; register 0 is a read-only ID word.
// Latency: the access phase lasts WAIT_CYC+1 cycles; PRDATA/PREADY/PSLVERR are registered.
// Backpressure: PREADY is held low for WAIT_CYC access cycles; dropping PSEL aborts the transfer.
//
// Ports:
//   PCLK, PRESETn                      clock and asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request from the master
//   WAIT_CYC_slv_i                     wait states for this transfer, sampled in setup
//   PRDATA/PREADY/PSLVERR              registered APB response
module apb_slave_regfile #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA0B0_0001
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL_slv_i,
    input  logic                  PENABLE_slv_i,
    input  logic                  PWRITE_slv_i,
    input  logic [ADDR_WIDTH-1:0] PADDR_slv_i,
    input  logic [DATA_WIDTH-1:0] PWDATA_slv_i,
    input  logic [3:0]            WAIT_CYC_slv_i,
    output logic [DATA_WIDTH-1:0] PRDATA_slv_o,
    output logic                  PREADY_slv_o,
    output logic                  PSLVERR_slv_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WIDX  = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  slverr_q, slverr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Setup-phase latch: the access phase never looks at the live bus.
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  latch_en;
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // Live decode of the request currently on the bus.
    logic [WIDX-1:0] idx_in;
    logic            err_in;
    assign idx_in = PADDR_slv_i[ADDR_WIDTH-1:2];
    assign err_in = (PADDR_slv_i[1:0] != 2'b00)
                  | (idx_in >= WIDX'(NUM_REGS))
                  | (PWRITE_slv_i & (idx_in == '0));

    // Read word: the zero-wait path uses the live decode because the latch
    // only loads on the same edge that drives the response.
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] rd_word;
    always_comb begin
        sel_idx = idx_q;
        sel_err = err_q;
        if (state_q == ST_IDLE) begin
            sel_idx = idx_in[IDX_W-1:0];
            sel_err = err_in;
        end
        rd_word = '0;
        if (!sel_err) begin
            rd_word = (sel_idx == '0) ? ID_VALUE : regs_q[sel_idx];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        slverr_d = slverr_q;
        rdata_d  = rdata_q;
        latch_en = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d  = 1'b0;
                slverr_d = 1'b0;
                if (PSEL_slv_i && !PENABLE_slv_i) begin
                    latch_en = 1'b1;
                    if (WAIT_CYC_slv_i == 4'd0) begin
                        state_d  = ST_RESP;
                        ready_d  = 1'b1;
                        slverr_d = err_in;
                        if (!PWRITE_slv_i) begin
                            rdata_d = rd_word;
                        end
                    end else begin
                        cnt_d   = WAIT_CYC_slv_i;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL_slv_i) begin
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                end else if (PENABLE_slv_i) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d  = ST_RESP;
                        ready_d  = 1'b1;
                        slverr_d = err_q;
                        if (!wr_q) begin
                            rdata_d = rd_word;
                        end
                    end
                end
            end
            ST_RESP: begin
                if (!PSEL_slv_i) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                end else if (PENABLE_slv_i && ready_q) begin
                    wr_en    = wr_q & ~err_q;
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ready_d  = 1'b0;
                slverr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            if (latch_en) begin
                idx_q   <= idx_in[IDX_W-1:0];
                wr_q    <= PWRITE_slv_i;
                err_q   <= err_in;
                wdata_q <= PWDATA_slv_i;
            end
        end
    end

    // Entry 0 is never written; reads of index 0 are served by ID_VALUE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[idx_q] <= wdata_q;
        end
    end

    assign PRDATA_slv_o  = rdata_q;
    assign PREADY_slv_o  = ready_q;
    assign PSLVERR_slv_o = slverr_q;

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB responder holding a bank of NUM_REGS word-wide registers. It is the completer side for the team's APB master and is used as the target in system tests and as a generic configuration-register block. It supports a programmable number of wait states, returns PSLVERR for illegal accesses, and exposes register 0 as a read-only ID word.

Parameters:
DATA_WIDTH, 32, width of PWDATA/PRDATA and of each register
ADDR_WIDTH, 32, width of PADDR
NUM_REGS, 16, number of registers (word-addressed; valid range 2..256)
ID_VALUE, 32'hA0B0_0001, constant value returned by register 0

Ports:
PCLK  in  1  clock; all logic on its rising edge
PRESETn  in  1  reset, asynchronous, active-low
PSEL_slv_i  in  1  APB select
PENABLE_slv_i  in  1  APB enable (access phase)
PWRITE_slv_i  in  1  1 = write, 0 = read
PADDR_slv_i  in  ADDR_WIDTH  byte address
PWDATA_slv_i  in  DATA_WIDTH  write data
WAIT_CYC_slv_i  in  4  wait states to insert per transfer; sampled in the setup phase
PRDATA_slv_o  out  DATA_WIDTH  read data, registered
PREADY_slv_o  out  1  transfer completion, registered
PSLVERR_slv_o  out  1  error response, registered; meaningful only while PREADY = 1

Behaviour:
- Reset (PRESETn = 0, asynchronous): PRDATA = 0, PREADY = 0, PSLVERR = 0, registers 1..NUM_REGS-1 = 0, FSM = IDLE, wait counter = 0. Any transfer in flight is discarded and nothing is written.
- Decode: idx = PADDR[ADDR_WIDTH-1:2].
  - Access is legal iff PADDR[1:0] == 0, idx < NUM_REGS, and the access is not a write to idx 0.
  - Illegal access: PSLVERR = 1 together with PREADY, no register change, PRDATA = 0.
- Registers idx 0 (read) returns ID_VALUE.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> setup phase seen (PSEL = 1, PENABLE = 0):
    - Latch PADDR, PWRITE, PWDATA, and the error flag.
    - If WAIT_CYC = 0, go to RESP and set PREADY = 1 (read data and PSLVERR driven in the same edge).
    - Otherwise load cnt = WAIT_CYC and go to WAIT with PREADY = 0.
  - WAIT -> each edge with PSEL & PENABLE decrements cnt.
    - When cnt == 1, go to RESP and set PREADY = 1 (with PRDATA/PSLVERR).
    - PSEL = 0 in WAIT (master abort): go to IDLE, no write, outputs cleared to 0 except PRDATA (holds).
  - RESP -> the edge with PSEL & PENABLE & PREADY completes the transfer:
    - A legal write commits latched PWDATA to reg[idx].
    - Clear PREADY and PSLVERR; go to IDLE.
    - PSEL = 0 in RESP: treat as abort (no write, go to IDLE).
- Latency: the access phase lasts exactly W+1 cycles for W = WAIT_CYC. A zero-wait transfer is 2 cycles (setup + access).
- Back-to-back transfers: a new setup phase may arrive the cycle after completion; IDLE accepts it with no idle gap.
- PRDATA:
  - Updated only when PREADY rises for a read (register value, ID_VALUE, or 0 on error).
  - Holds its value otherwise, including during writes.
- Address, write data, and direction are taken from the setup-phase latch. Changes on APB inputs during the access phase are ignored.
- Read-after-write to the same register in consecutive transfers returns the newly written value.

Test Plan:
- Reset: assert PRESETn = 0 mid-transfer in WAIT -> PREADY, PSLVERR, and PRDATA go to 0 immediately (before the clock edge); reg 3 reads back 0 afterwards.
- Zero-wait write then read: WAIT_CYC = 0, write 0xDEADBEEF to addr 0x0C, then read 0x0C -> PREADY = 1 in the first access cycle of each transfer; PRDATA = 0xDEADBEEF; PSLVERR = 0; each transfer takes 2 cycles.
- Wait states: WAIT_CYC = 3, read addr 0x00 -> PREADY low for 3 access cycles and high in the 4th; PRDATA = 0xA0B00001.
- Errors, with WAIT_CYC = 0:
  - Write addr 0x00 -> PSLVERR = 1; a subsequent read of 0x00 still returns ID_VALUE.
  - Read addr 0x40 (idx 16) -> PSLVERR = 1, PRDATA = 0.
  - Write addr 0x06 (misaligned) -> PSLVERR = 1; reg 1 unchanged.
- Abort: WAIT_CYC = 5, write 0x1234 to 0x08, drop PSEL after 2 access cycles -> FSM returns to IDLE, PREADY never asserts, reg 2 unchanged (reads 0).
- Back-to-back: three consecutive writes to 0x04/0x08/0x0C with no idle cycle, WAIT_CYC = 1 -> each completes in 2 access cycles; reads return the written values.
